// File: rtl/alu_result_display.sv
// Converts a captured ALU result to sign + two BCD digits (shift-add-3) and scans a 4-digit 7-seg display.
// Latency: done pulses WIDTH+2 clocks after the init-sampling edge; display scanning is free-running.
// Backpressure: none; init is ignored while busy, the display holds the last result during conversion.
module alu_result_display #(
    parameter int WIDTH       = 6,
    parameter bit SIGNED      = 1'b1,
    parameter int REFRESH_DIV = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] val,
    output logic             busy,
    output logic             done,
    output logic [3:0]       an,
    output logic [6:0]       seg,
    output logic             dp
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam int RW = $clog2(REFRESH_DIV);

    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] mag;
    logic [7:0]       bcd;
    logic [7:0]       bcd_adj;
    logic [CW-1:0]    cnt;
    logic             neg;

    logic             sign_on;
    logic [3:0]       tens;
    logic [3:0]       units;

    logic [RW-1:0]    rcnt;
    logic [1:0]       idx;

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    function automatic logic [6:0] dec7(input logic [3:0] n);
        case (n)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return SEG_BLANK;
        endcase
    endfunction

    always_comb begin
        bcd_adj = {add3(bcd[7:4]), add3(bcd[3:0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            mag     <= '0;
            bcd     <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            sign_on <= 1'b0;
            tens    <= 4'd0;
            units   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (init) begin
                        neg   <= SIGNED & val[WIDTH-1];
                        mag   <= (SIGNED && val[WIDTH-1]) ? -val : val;
                        bcd   <= '0;
                        cnt   <= CW'(WIDTH);
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {bcd, mag} <= {bcd_adj, mag} << 1;
                    cnt        <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // A zero magnitude never shows a minus sign.
                    sign_on <= neg && (bcd != 8'd0);
                    tens    <= bcd[7:4];
                    units   <= bcd[3:0];
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt <= '0;
            idx  <= 2'd0;
        end else if (rcnt == RW'(REFRESH_DIV - 1)) begin
            rcnt <= '0;
            idx  <= idx + 2'd1;
        end else begin
            rcnt <= rcnt + RW'(1);
        end
    end

    always_comb begin
        an  = ~(4'b0001 << idx);
        seg = SEG_BLANK;
        case (idx)
            2'd0:    seg = dec7(units);
            2'd1:    seg = (tens == 4'd0) ? SEG_BLANK : dec7(tens);
            2'd2:    seg = sign_on ? SEG_DASH : SEG_BLANK;
            default: seg = SEG_BLANK;
        endcase
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench: stimulus pushes expected displays (signed and unsigned instances), a monitor pops on done.
module tb_alu_result_display;
    localparam logic [6:0] B  = 7'b1111111;
    localparam logic [6:0] M  = 7'b0111111;
    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       init = 1'b0;
    logic [5:0] val = 6'd0;
    logic       busy_s, done_s, dp_s, busy_u, done_u, dp_u;
    logic [3:0] an_s, an_u;
    logic [6:0] seg_s, seg_u;

    typedef struct {
        logic [27:0] s;
        logic [27:0] u;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt_s = 0;
    int   done_cnt_u = 0;

    alu_result_display #(.WIDTH(6), .SIGNED(1'b1), .REFRESH_DIV(4)) dut_s (
        .clk(clk), .rst(rst), .init(init), .val(val),
        .busy(busy_s), .done(done_s), .an(an_s), .seg(seg_s), .dp(dp_s)
    );

    alu_result_display #(.WIDTH(6), .SIGNED(1'b0), .REFRESH_DIV(4)) dut_u (
        .clk(clk), .rst(rst), .init(init), .val(val),
        .busy(busy_u), .done(done_u), .an(an_u), .seg(seg_u), .dp(dp_u)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (done_s === 1'b1) done_cnt_s <= done_cnt_s + 1;
        if (done_u === 1'b1) done_cnt_u <= done_cnt_u + 1;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Samples at successive negedges until every digit slot has been seen once.
    task automatic capture(output logic [27:0] gs, output logic [27:0] gu, output logic ok);
        logic [3:0] seen;
        int         slot;
        seen = 4'h0;
        gs   = '1;
        gu   = '1;
        for (int i = 0; i < 24 && seen != 4'hF; i++) begin
            if (i > 0) @(negedge clk);
            case (an_s)
                4'b1110: slot = 0;
                4'b1101: slot = 1;
                4'b1011: slot = 2;
                4'b0111: slot = 3;
                default: slot = -1;
            endcase
            if (slot >= 0) begin
                gs[slot*7 +: 7] = seg_s;
                gu[slot*7 +: 7] = seg_u;
                seen[slot]      = 1'b1;
            end
        end
        ok = (seen == 4'hF);
    endtask

    initial begin : monitor
        exp_t        e;
        logic [27:0] gs, gu;
        logic        ok;
        forever begin
            @(negedge clk);
            if (done_s === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_cycle", cyc, e.cyc);
                    check("done_u_aligned", {31'd0, done_u}, 32'd1);
                    capture(gs, gu, ok);
                    check("scan_complete", {31'd0, ok}, 32'd1);
                    check("display_signed", {4'd0, gs}, {4'd0, e.s});
                    check("display_unsigned", {4'd0, gu}, {4'd0, e.u});
                end
            end
        end
    end

    task automatic run_conv(input logic [5:0] v, input logic [27:0] es, input logic [27:0] eu);
        exp_t e;
        int   d0;
        d0 = done_cnt_s;
        @(negedge clk);
        val   = v;
        init  = 1'b1;
        e.s   = es;
        e.u   = eu;
        e.cyc = cyc + 8;
        q.push_back(e);
        @(negedge clk);
        init = 1'b0;
        check("busy_edge0", {31'd0, busy_s}, 32'd1);
        repeat (6) @(negedge clk);
        check("busy_edge6", {31'd0, busy_s}, 32'd1);
        @(negedge clk);
        check("busy_edge7", {31'd0, busy_s}, 32'd0);
        repeat (28) @(negedge clk);
        check("done_count", done_cnt_s - d0, 32'd1);
    endtask

    initial begin : stimulus
        logic [27:0] gs, gu;
        logic        ok;
        int          d0;
        logic [3:0]  exp_an;

        repeat (2) @(negedge clk);
        check("rst_an", {28'd0, an_s}, {28'd0, 4'b1110});
        check("rst_seg", {25'd0, seg_s}, {25'd0, S0});
        check("rst_dp_busy_done", {29'd0, dp_s, busy_s, done_s}, {29'd0, 3'b100});
        rst = 1'b0;

        // Idle scan: the index advances every fourth edge after release.
        gs = '1;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            exp_an = ~(4'b0001 << ((i / 4) % 4));
            check("idle_an", {28'd0, an_s}, {28'd0, exp_an});
            check("idle_busy_done", {30'd0, busy_s, done_s}, 32'd0);
            if (i % 4 == 0) gs[((i / 4) % 4)*7 +: 7] = seg_s;
        end
        check("idle_display", {4'd0, gs}, {4'd0, B, B, B, S0});

        run_conv(6'd7,       {B, B, B, S7}, {B, B, B, S7});
        run_conv(6'b111101,  {B, M, B, S3}, {B, B, S6, S1});
        run_conv(6'b100000,  {B, M, S3, S2}, {B, B, S3, S2});
        run_conv(6'b111111,  {B, M, B, S1}, {B, B, S6, S3});
        run_conv(6'd0,       {B, B, B, S0}, {B, B, B, S0});

        // Second init while busy must be ignored.
        d0 = done_cnt_s;
        @(negedge clk);
        val  = 6'd5;
        init = 1'b1;
        q.push_back('{s: {B, B, B, S5}, u: {B, B, B, S5}, cyc: cyc + 8});
        @(negedge clk);
        init = 1'b0;
        @(negedge clk);
        val  = 6'd3;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        repeat (40) @(negedge clk);
        check("ignored_init_done_count", done_cnt_s - d0, 32'd1);

        // Reset at edge 3 of a conversion aborts it.
        d0 = done_cnt_s;
        @(negedge clk);
        val  = 6'd9;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy_s}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt_s - d0, 32'd0);
        capture(gs, gu, ok);
        check("abort_scan_complete", {31'd0, ok}, 32'd1);
        check("abort_display", {4'd0, gs}, {4'd0, B, B, B, S0});
        repeat (5) @(negedge clk);

        run_conv(6'd9, {B, B, B, S9}, {B, B, B, S9});

        check("scoreboard_empty", q.size(), 32'd0);
        check("done_count_match", done_cnt_u, done_cnt_s);
        check("dp_off", {30'd0, dp_s, dp_u}, 32'd3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule

// File: doc/alu_result_display.md
Name: alu_result_display

Overview:
- Downstream consumer of the ALU arithmetic units; takes the 6-bit result bus `sal` from the active operation.
- Captures the result on a load strobe and converts it sequentially to sign plus two BCD digits using shift-add-3, one bit per clock.
- Drives a 4-digit common-anode 7-segment display by time multiplexing.

Parameters:
- WIDTH, 6: result width; the conversion takes WIDTH shift cycles.
- SIGNED, 1: 1 means `val` is two's complement; 0 means unsigned.
- REFRESH_DIV, 50000: clocks per digit slot during scanning; must be at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- init  in  1  load strobe; samples `val` when the block is idle
- val  in  WIDTH  ALU result (`sal`)
- busy  out  1  high while a conversion is in progress
- done  out  1  one-cycle pulse when the display registers update
- an  out  4  anode selects, active-low, one-hot
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low; held 1 (off)

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, busy=0, done=0, digit index=0, refresh counter=0.
  - Display registers set to: sign off, tens blank, units 0.
  - Outputs: an=4'b1110, seg=7'b1000000, dp=1.
  - A reset during a conversion aborts it; no done pulse is produced.
- State machine: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE:
  - On an edge with init=1, capture neg = SIGNED & val[WIDTH-1].
  - Capture mag = neg ? -val : val, taken as unsigned WIDTH bits (val=100000 gives mag=32).
  - Clear the BCD shift register, load bit count = WIDTH, set busy=1, go to SHIFT.
- SHIFT, once per edge:
  - Add 3 to each BCD nibble that is >= 5.
  - Then shift {bcd, mag} left by 1 and decrement the count.
  - The edge that performs the WIDTH-th shift moves to DONE.
- DONE, one edge:
  - Load the display registers: sign, tens, units.
  - done=1 for exactly one cycle; busy=0; return to IDLE.
- Latency: taking the init-sampling edge as edge 0, done is high in the cycle following edge WIDTH+1. Busy is high from edge 0 up to edge WIDTH+1.
- init while busy is ignored. Holding init high restarts a conversion on the first IDLE edge after done.
- Display registers change only in DONE; the display keeps showing the previous result during a conversion.
- Digit contents:
  - digit3: always blank.
  - digit2: '-' if neg and mag!=0, else blank.
  - digit1: tens, blanked when tens=0 (leading-zero suppression).
  - digit0: units, always shown.
  - With SIGNED=0, digit2 is always blank.
- Scanning:
  - The refresh counter counts 0..REFRESH_DIV-1 continuously and independently of the FSM.
  - On wrap, the digit index increments 0->1->2->3->0.
  - an = ~(1<<index); seg decodes the selected digit combinationally.
- Segment encodings:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - '-'=0111111, blank=1111111
  - Tens never exceeds 6 for WIDTH=6.

Test Plan (REFRESH_DIV=4 for simulation):
- Reset, then 16 clocks with no init -> busy=0, done=0. an cycles 1110, 1101, 1011, 0111, changing every 4 clocks. Digit0 shows seg=1000000; the other three digits show 1111111.
- init pulse with val=6'd7 -> busy high for edges 0..6, done pulse after edge 7. Digit0=1111000; digits 1, 2 and 3 blank.
- val=6'b111101 (-3) -> digit2=0111111, digit1 blank, digit0=0110000.
- val=6'b100000 (-32) -> digit2='-' (0111111), digit1='3' (0110000), digit0='2' (0100100). The same input with SIGNED=0 displays 32 with no sign.
- Second init 2 cycles after the first, with a different val -> ignored. Exactly one done pulse; the display shows the first value.
- rst asserted at edge 3 of a conversion of val=6'd9 -> no done pulse. Display returns to the reset pattern and the FSM is idle. A subsequent init converts correctly, showing units=0010000 ('9').
